// File: rtl/stream_pkg.sv
// Shared types for the stream arbiter: FSM state encoding,
// tag marker nibble and the largest supported requester count.
package stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TAG   = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  localparam logic [3:0] TAG_MARK = 4'hA;
  localparam int         MAX_N    = 16;

endpackage

// File: rtl/stream_arbiter_if.sv
// Bundle of the arbiter's requester and output stream signals.
// master: arbiter side (drives in_ready/out_*/grant); slave: the environment.
interface stream_arbiter_if #(
  parameter int N = 4
);

  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [8*N-1:0] in_data;
  logic           out_valid;
  logic           out_ready;
  logic [7:0]     out_data;
  logic [N-1:0]   grant;

  modport master (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, grant
  );

  modport slave (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, grant
  );

endinterface

// File: rtl/stream_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority encoder.
// Ports: req (requests), last (previous winner) -> gnt (one-hot), idx, any.
module rr_pick
  import stream_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic hit;

  // Offsets 1..N from last visit every index once, nearest first,
  // so the previous winner is considered only when nobody else asks.
  always_comb begin
    gnt = '0;
    idx = '0;
    hit = 1'b0;
    for (int k = 1; k <= N; k++) begin
      for (int j = 0; j < N; j++) begin
        if (!hit && req[j] &&
            j == (int'(last) + k) % N) begin
          hit    = 1'b1;
          gnt[j] = 1'b1;
          idx    = IW'(j);
        end
      end
    end
    any = |req;
  end

endmodule

// File: rtl/stream_arbiter.sv
// Burst round-robin arbiter: N byte requesters share one valid/ready stream.
// Ports: clk, rst (async, high), bus (stream_arbiter_if.master).
// Optional STREAM_ARBITER_TAG_EN: emit {A, owner} tag byte before each burst.
module stream_arbiter
  import stream_pkg::*;
#(
  parameter int N     = 4,
  parameter int BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  stream_arbiter_if.master  bus
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(BURST + 1);

  state_t          state_q, state_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [IW-1:0]   last_q, last_d;
  logic [CW-1:0]   count_q, count_d;

  logic [N-1:0]    pick_oh;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;

  logic            owner_valid;
  logic [7:0]      owner_data;
  logic [CW-1:0]   count_inc;
  logic            last_beat;

  logic            out_valid_c;
  logic [7:0]      out_data_c;
  logic [N-1:0]    in_ready_c;

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req  (bus.in_valid),
    .last (last_q),
    .gnt  (pick_oh),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // last_q doubles as the owner index while a grant is held.
  always_comb begin
    owner_valid = 1'b0;
    owner_data  = '0;
    for (int j = 0; j < N; j++) begin
      if (last_q == IW'(j)) begin
        owner_valid = bus.in_valid[j];
        owner_data  = bus.in_data[8*j +: 8];
      end
    end
  end

  assign count_inc = count_q + 1'b1;
  assign last_beat = (count_inc == CW'(BURST));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= IW'(N - 1);
      count_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    count_d = count_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_oh;
          last_d  = pick_idx;
          count_d = '0;
`ifdef STREAM_ARBITER_TAG_EN
          state_d = ST_TAG;
`else
          state_d = ST_BURST;
`endif
        end
      end
`ifdef STREAM_ARBITER_TAG_EN
      ST_TAG: begin
        if (bus.out_ready) state_d = ST_BURST;
      end
`endif
      ST_BURST: begin
        if (!owner_valid) begin
          state_d = ST_IDLE;
          grant_d = '0;
          count_d = '0;
        end else if (bus.out_ready) begin
          if (last_beat) begin
            state_d = ST_IDLE;
            grant_d = '0;
            count_d = '0;
          end else begin
            count_d = count_inc;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        count_d = '0;
      end
    endcase
  end

  always_comb begin
    out_valid_c = 1'b0;
    out_data_c  = '0;
    in_ready_c  = '0;
    unique case (state_q)
`ifdef STREAM_ARBITER_TAG_EN
      ST_TAG: begin
        out_valid_c = 1'b1;
        out_data_c  = {TAG_MARK, 4'(last_q)};
      end
`endif
      ST_BURST: begin
        out_valid_c = owner_valid;
        out_data_c  = owner_data;
        in_ready_c  = grant_q & {N{bus.out_ready}};
      end
      default: begin
        out_valid_c = 1'b0;
      end
    endcase
  end

  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = out_data_c;
  assign bus.in_ready  = in_ready_c;
  assign bus.grant     = grant_q;

endmodule

// File: tb/tb_stream_arbiter.sv
// Directed bench for stream_arbiter with a per-cycle reference model.
module tb_stream_arbiter;
  import stream_pkg::*;

  localparam int N     = 4;
  localparam int BURST = 4;
`ifdef STREAM_ARBITER_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stream_arbiter_if #(.N(N)) bus ();

  stream_arbiter #(
    .N     (N),
    .BURST (BURST)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int oh_idx(logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return -1;
  endfunction

  // Reference model: who owns the stream, bytes sent, tag pending.
  int m_owner = -1;
  int m_last  = N - 1;
  int m_cnt   = 0;
  bit m_tag   = 1'b0;

  always @(posedge clk or posedge rst) begin : model
    int c;
    if (rst) begin
      m_owner = -1;
      m_last  = N - 1;
      m_cnt   = 0;
      m_tag   = 1'b0;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (bus.in_valid[c]) begin
          m_owner = c;
          m_last  = c;
          m_cnt   = 0;
          m_tag   = TAG_EN;
          break;
        end
      end
    end else if (m_tag) begin
      if (bus.out_ready) m_tag = 1'b0;
    end else if (!bus.in_valid[m_owner]) begin
      m_owner = -1;
    end else if (bus.out_ready) begin
      m_cnt++;
      if (m_cnt == BURST) m_owner = -1;
    end
  end

  always @(negedge clk) begin : compare
    logic [N-1:0] eg, er;
    logic         ev, dchk;
    logic [7:0]   ed;
    eg = '0; er = '0; ev = 1'b0; ed = '0; dchk = 1'b1;
    if (!rst && m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      if (m_tag) begin
        ev = 1'b1;
        ed = 8'hA0 | 8'(m_owner);
      end else begin
        ev = bus.in_valid[m_owner];
        ed = bus.in_data[8*m_owner +: 8];
        er[m_owner] = bus.out_ready;
        dchk = ev;
      end
    end
    chk("grant", 32'(bus.grant), 32'(eg));
    chk("out_valid", 32'(bus.out_valid), 32'(ev));
    chk("in_ready", 32'(bus.in_ready), 32'(er));
    if (dchk) chk("out_data", 32'(bus.out_data), 32'(ed));
  end

  // Producers: one byte queue per requester, out_ready pattern queue.
  logic [7:0] q [N][$];
  logic       orq[$];
  int         cyc_n;
  logic [7:0] cap_d[$];
  int         cap_o[$];
  int         cap_c[$];
  logic [7:0] stall_d[$];

  task automatic clear_cap();
    cap_d.delete(); cap_o.delete(); cap_c.delete();
    stall_d.delete();
    cyc_n = 0;
  endtask

  task automatic run(int n);
    repeat (n) begin
      logic [N-1:0] xf;
      for (int i = 0; i < N; i++) begin
        bus.in_valid[i] = (q[i].size() > 0);
        bus.in_data[8*i +: 8] = (q[i].size() > 0) ? q[i][0] : 8'h00;
      end
      bus.out_ready = (orq.size() > 0) ? orq.pop_front() : 1'b1;
      @(negedge clk);
      xf = bus.in_valid & bus.in_ready;
      if (bus.out_valid && bus.out_ready) begin
        cap_d.push_back(bus.out_data);
        cap_o.push_back(oh_idx(bus.grant));
        cap_c.push_back(cyc_n);
      end
      if (bus.out_valid && !bus.out_ready)
        stall_d.push_back(bus.out_data);
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++)
        if (xf[i]) void'(q[i].pop_front());
      cyc_n++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) q[i].delete();
    orq.delete();
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset with random inputs
    repeat (3) begin
      bus.in_valid  = 4'($urandom);
      bus.in_data   = 32'($urandom);
      bus.out_ready = 1'($urandom);
      @(negedge clk);
      chk("rst_grant", 32'(bus.grant), 0);
      chk("rst_oval", 32'(bus.out_valid), 0);
      chk("rst_rdy", 32'(bus.in_ready), 0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;

    // First request on 1 and 3: 1 wins, then 3
    clear_cap();
    q[1].push_back(8'h01);
    q[3].push_back(8'h03);
    run(1);
    chk("first_grant", 32'(bus.grant), 32'h2);
    run(8);
    chk("t1_n", cap_d.size(), 2);
    chk("t1_d0", 32'(cap_d[0]), 32'h01);
    chk("t1_o0", cap_o[0], 1);
    chk("t1_d1", 32'(cap_d[1]), 32'h03);
    chk("t1_o1", cap_o[1], 3);

    // Single requester, 6 bytes: 4 + bubble + 2
    clear_cap();
    for (int k = 0; k < 6; k++) q[1].push_back(8'(8'h10 + k));
    run(12);
    begin
      int ec[6] = '{1, 2, 3, 4, 6, 7};
      chk("t2_n", cap_d.size(), 6);
      for (int k = 0; k < 6; k++) begin
        chk("t2_d", 32'(cap_d[k]), 32'(8'h10 + k));
        chk("t2_o", cap_o[k], 1);
        chk("t2_c", cap_c[k], ec[k]);
      end
    end
    chk("t2_idle", 32'(bus.grant), 0);

    // All four busy: order 0,1,2,3,0, one bubble per grant
    do_reset();
    clear_cap();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 8; k++)
        q[i].push_back(8'(i * 16 + k));
    run(25);
    chk("t3_n", cap_d.size(), 20);
    for (int b = 0; b < 5; b++)
      for (int k = 0; k < 4; k++) begin
        chk("t3_o", cap_o[b*4+k], b % 4);
        chk("t3_d", 32'(cap_d[b*4+k]),
            32'((b % 4) * 16 + (b / 4) * 4 + k));
        chk("t3_c", cap_c[b*4+k], b * 5 + 1 + k);
      end
    for (int i = 0; i < N; i++) q[i].delete();
    run(3);

    // Backpressure after byte 2
    do_reset();
    clear_cap();
    for (int k = 0; k < 6; k++) q[0].push_back(8'(8'h40 + k));
    orq = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    run(13);
    begin
      int ec[6] = '{1, 2, 6, 7, 9, 10};
      chk("t4_n", cap_d.size(), 6);
      for (int k = 0; k < 6; k++) begin
        chk("t4_d", 32'(cap_d[k]), 32'(8'h40 + k));
        chk("t4_c", cap_c[k], ec[k]);
      end
      chk("t4_stall_n", stall_d.size(), 3);
      for (int k = 0; k < 3; k++)
        chk("t4_stall_d", 32'(stall_d[k]), 32'h42);
    end

    // Early end: 0 stops after 2 bytes, 2 takes over
    do_reset();
    clear_cap();
    q[0] = '{8'h50, 8'h51};
    q[2] = '{8'h70, 8'h71};
    run(10);
    begin
      int eo[4] = '{0, 0, 2, 2};
      logic [7:0] ed[4] = '{8'h50, 8'h51, 8'h70, 8'h71};
      int ec[4] = '{1, 2, 5, 6};
      chk("t5_n", cap_d.size(), 4);
      for (int k = 0; k < 4; k++) begin
        chk("t5_o", cap_o[k], eo[k]);
        chk("t5_d", 32'(cap_d[k]), 32'(ed[k]));
        chk("t5_c", cap_c[k], ec[k]);
      end
    end

    // Requester 2 sends 0x55,0x66 (tag first when enabled)
    do_reset();
    clear_cap();
    q[2] = '{8'h55, 8'h66};
    run(6);
    begin
`ifdef STREAM_ARBITER_TAG_EN
      logic [7:0] ed[3] = '{8'hA2, 8'h55, 8'h66};
      int en = 3;
`else
      logic [7:0] ed[3] = '{8'h55, 8'h66, 8'h00};
      int en = 2;
`endif
      chk("t6_n", cap_d.size(), en);
      for (int k = 0; k < en; k++) begin
        chk("t6_d", 32'(cap_d[k]), 32'(ed[k]));
        chk("t6_o", cap_o[k], 2);
      end
    end

    // Reset in the first owned cycle (TAG or BURST)
    do_reset();
    clear_cap();
    q[2] = '{8'h77, 8'h88};
    run(1);
    chk("t7_pre_oval", 32'(bus.out_valid), 1);
    rst = 1'b1;
    #1;
    chk("t7_oval", 32'(bus.out_valid), 0);
    chk("t7_grant", 32'(bus.grant), 0);
    chk("t7_rdy", 32'(bus.in_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < N; i++) q[i].delete();
    clear_cap();
    run(3);
    chk("t7_none", cap_d.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
